i2c_codec_target: RTL

- I2C target (responder) that models the WM8731 codec control port.
- It is the far end of the existing I2C configuration initiator. It decodes 3-byte write transactions: device address, then {reg[6:0], data[8]}, then data[7:0].
- It ACKs each byte and holds a 9-bit register file with WM8731 reset defaults.
- Used in the simulation bench and as an on-FPGA loopback checker for codec initialisation.

---
 rtl/i2c_codec_pkg.sv | 13 +
 rtl/i2c_line_cond.sv | 72 +++++++
 rtl/i2c_codec_target.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/i2c_codec_pkg.sv
// i2c_codec_pkg: shared state encoding, WM8731 register map size and reset defaults.
package i2c_codec_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, IGNORE
    } state_e;
    localparam int NUM_REGS  = 10;
    localparam int RESET_REG = 15;
    // R9 down to R0
    localparam logic [NUM_REGS-1:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: SCL/SDA synchroniser, optional glitch filter (I2C_CODEC_TARGET_GLITCH_FILTER_EN) and edge/START/STOP strobes.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
    ,
    parameter int FILT_CYCLES = 4
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [1:0] raw, line, prev_q, prev_d;
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    end
    assign raw    = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};
    assign prev_d = line;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            prev_q     <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            prev_q     <= prev_d;
        end
    end
`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_CYCLES) + 1;
    logic [1:0] filt_q, filt_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] == filt_q[i]) cnt_d[i] = '0;
            else if (cnt_q[i] == CW'(FILT_CYCLES - 1)) begin
                filt_d[i] = raw[i];
                cnt_d[i]  = '0;
            end else cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filt_q <= '1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end
    assign line = filt_q;
`else
    assign line = raw;
`endif
    // bit 1 is SCL, bit 0 is SDA
    assign o_sda      = line[0];
    assign o_scl_rise = line[1] & ~prev_q[1];
    assign o_scl_fall = ~line[1] & prev_q[1];
    assign o_start    = line[1] & prev_q[1] & prev_q[0] & ~line[0];
    assign o_stop     = line[1] & prev_q[1] & ~prev_q[0] & line[0];
endmodule

// File: rtl/i2c_codec_target.sv
// i2c_codec_target: WM8731 control-port I2C write target with register file; glitch filter via I2C_CODEC_TARGET_GLITCH_FILTER_EN.
module i2c_codec_target
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
    ,
    parameter int         FILT_CYCLES = 4
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_bad_addr
);
    logic sda, scl_rise, scl_fall, start, stop;
    state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d, bad_addr_q, bad_addr_d, d8_q, d8_d;
    logic [6:0] wr_addr_q, wr_addr_d, reg_addr_q, reg_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0][8:0] regs_q, regs_d;
    logic byte_done, sampling, addr_ok;
    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
        ,
        .FILT_CYCLES(FILT_CYCLES)
`endif
    ) u_line (
        .i_clk(i_clk), .i_rst(i_rst), .i_scl(i_scl), .i_sda(i_sda),
        .o_sda(sda), .o_scl_rise(scl_rise), .o_scl_fall(scl_fall),
        .o_start(start), .o_stop(stop)
    );
    assign byte_done = bit_cnt_q == 4'd8;
    assign sampling  = state_q inside {ADDR, BYTE_HI, BYTE_LO};
    assign addr_ok   = shift_q == {DEV_ADDR, 1'b0};
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_addr_d = reg_addr_q;
        d8_d       = d8_q;
        regs_d     = regs_q;
        bad_addr_d = bad_addr_q;
        if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (scl_rise && sampling && !byte_done) begin
            shift_d   = {shift_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (byte_done) begin
                    sda_oe_d  = addr_ok;
                    state_d   = addr_ok ? ACK_ADDR : IGNORE;
                    bit_cnt_d = '0;
                end
                ACK_ADDR: begin
                    sda_oe_d = 1'b0;
                    state_d  = BYTE_HI;
                end
                BYTE_HI: if (byte_done) begin
                    reg_addr_d = shift_q[7:1];
                    d8_d       = shift_q[0];
                    sda_oe_d   = 1'b1;
                    state_d    = ACK_HI;
                    bit_cnt_d  = '0;
                end
                ACK_HI: begin
                    sda_oe_d = 1'b0;
                    state_d  = BYTE_LO;
                end
                BYTE_LO: if (byte_done) begin
                    sda_oe_d  = 1'b1;
                    state_d   = ACK_LO;
                    bit_cnt_d = '0;
                end
                ACK_LO: begin
                    sda_oe_d   = 1'b0;
                    state_d    = IGNORE;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = reg_addr_q;
                    wr_data_d  = {d8_q, shift_q};
                    if (reg_addr_q < 7'(NUM_REGS)) regs_d[reg_addr_q[3:0]] = {d8_q, shift_q};
                    else if (reg_addr_q == 7'(RESET_REG)) regs_d = ({d8_q, shift_q} == '0) ? REG_DEFAULTS : regs_q;
                    else bad_addr_d = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            reg_addr_q <= '0;
            d8_q       <= 1'b0;
            regs_q     <= REG_DEFAULTS;
            bad_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            reg_addr_q <= reg_addr_d;
            d8_q       <= d8_d;
            regs_q     <= regs_d;
            bad_addr_q <= bad_addr_d;
        end
    end
    assign o_sda_oe   = sda_oe_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_busy     = state_q != IDLE;
    assign o_bad_addr = bad_addr_q;
    assign o_rd_data  = (i_rd_addr < 4'(NUM_REGS)) ? regs_q[i_rd_addr] : '0;
endmodule
